// File: rtl/canny_pkg.sv
// Shared sizing parameters and FSM encoding for the Sobel window streamer.
package canny_pkg;
    localparam int PIXW  = 8;
    localparam int PPW   = 8;
    localparam int GW    = 11;
    localparam int WORDW = PIXW * PPW;
    localparam int NROWS = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;
endpackage

// File: rtl/sobel3x3.sv
// Combinational 3x3 Sobel operator on unsigned pixels; pRC is row R (top=0), column C (left=0).
module sobel3x3 #(
    parameter int PIXW = 8,
    parameter int GW   = 11
) (
    input  logic [PIXW-1:0]      p00,
    input  logic [PIXW-1:0]      p01,
    input  logic [PIXW-1:0]      p02,
    input  logic [PIXW-1:0]      p10,
    input  logic [PIXW-1:0]      p11,
    input  logic [PIXW-1:0]      p12,
    input  logic [PIXW-1:0]      p20,
    input  logic [PIXW-1:0]      p21,
    input  logic [PIXW-1:0]      p22,
    output logic signed [GW-1:0] gx,
    output logic signed [GW-1:0] gy
);
    logic [GW-1:0] left_sum;
    logic [GW-1:0] right_sum;
    logic [GW-1:0] top_sum;
    logic [GW-1:0] bottom_sum;

    // Weighted sums are non-negative; modular subtraction yields the two's complement result.
    assign left_sum   = GW'(p00) + (GW'(p10) << 1) + GW'(p20);
    assign right_sum  = GW'(p02) + (GW'(p12) << 1) + GW'(p22);
    assign top_sum    = GW'(p00) + (GW'(p01) << 1) + GW'(p02);
    assign bottom_sum = GW'(p20) + (GW'(p21) << 1) + GW'(p22);

    assign gx = $signed(right_sum - left_sum);
    assign gy = $signed(bottom_sum - top_sum);
endmodule

// File: rtl/canny_sobel_window.sv
// Streams four row words into two stacked 3x3 Sobel windows, one column beat per accepted cycle.
// Handshake: a transfer happens on a rising nclk edge where valid and ready are both high; valid holds its beat until accepted.
module canny_sobel_window #(
    parameter int PIXW = canny_pkg::PIXW,
    parameter int PPW  = canny_pkg::PPW,
    parameter int GW   = canny_pkg::GW
) (
    input  logic                 nclk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 line_start,
    input  logic [63:0]          rowA,
    input  logic [63:0]          rowB,
    input  logic [63:0]          rowC,
    input  logic [63:0]          rowD,
    output logic                 load_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [GW-1:0] gx0,
    output logic signed [GW-1:0] gy0,
    output logic signed [GW-1:0] gx1,
    output logic signed [GW-1:0] gy1,
    output logic [2:0]           col,
    output logic                 sol,
    output logic                 state
);
    import canny_pkg::*;

    localparam int WW = PIXW * PPW;
    localparam int CW = 2 * PIXW;

    state_t          state_q, state_d;
    logic [WW-1:0]   word_q  [NROWS];
    logic [WW-1:0]   word_d  [NROWS];
    logic [WW-1:0]   row_in  [NROWS];
    logic [CW-1:0]   carry_q [NROWS];
    logic [CW-1:0]   carry_d [NROWS];
    logic [WW+CW-1:0] ext    [NROWS];
    logic [PIXW-1:0] px      [NROWS][3];
    logic [2:0]      col_q, col_d;
    logic            sol_q, sol_d;
    logic            last_col;
    logic            accept;
    logic            beat_done;
    logic signed [GW-1:0] gx0_d, gy0_d, gx1_d, gy1_d;

    assign row_in[0] = rowA;
    assign row_in[1] = rowB;
    assign row_in[2] = rowC;
    assign row_in[3] = rowD;

    assign last_col  = (col_q == 3'(PPW - 1));
    assign accept    = load && load_ready;
    assign beat_done = (state_q == STREAM) && out_ready;

    // State register.
    always_ff @(posedge nclk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = STREAM;
            STREAM:  if (out_ready && last_col && !load) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        load_ready = (state_q == IDLE) || ((state_q == STREAM) && last_col && out_ready);
        out_valid  = (state_q == STREAM);
        state      = state_q;
    end

    // Carry columns are pixels 6 and 7 of the word being replaced, so the next word sees its left neighbours.
    always_comb begin
        col_d = col_q;
        sol_d = sol_q;
        for (int r = 0; r < NROWS; r++) begin
            word_d[r]  = word_q[r];
            carry_d[r] = carry_q[r];
        end
        if (accept) begin
            col_d = 3'd0;
            sol_d = line_start;
            for (int r = 0; r < NROWS; r++) begin
                word_d[r]  = row_in[r];
                carry_d[r] = line_start ? '0 : word_q[r][WW-1 -: CW];
            end
        end else if (beat_done) begin
            col_d = last_col ? 3'd0 : col_q + 3'd1;
        end
    end

    // Gradients are computed for the upcoming beat so the registered outputs match col.
    always_comb begin
        for (int r = 0; r < NROWS; r++) begin
            ext[r] = {word_d[r], carry_d[r]};
            for (int i = 0; i < 3; i++) begin
                px[r][i] = ext[r][(32'(col_d) + i) * PIXW +: PIXW];
            end
        end
    end

    sobel3x3 #(.PIXW(PIXW), .GW(GW)) u_sobel_top (
        .p00(px[0][0]), .p01(px[0][1]), .p02(px[0][2]),
        .p10(px[1][0]), .p11(px[1][1]), .p12(px[1][2]),
        .p20(px[2][0]), .p21(px[2][1]), .p22(px[2][2]),
        .gx (gx0_d),    .gy (gy0_d)
    );

    sobel3x3 #(.PIXW(PIXW), .GW(GW)) u_sobel_bot (
        .p00(px[1][0]), .p01(px[1][1]), .p02(px[1][2]),
        .p10(px[2][0]), .p11(px[2][1]), .p12(px[2][2]),
        .p20(px[3][0]), .p21(px[3][1]), .p22(px[3][2]),
        .gx (gx1_d),    .gy (gy1_d)
    );

    always_ff @(posedge nclk) begin
        if (reset) begin
            col_q <= 3'd0;
            sol_q <= 1'b0;
            gx0   <= '0;
            gy0   <= '0;
            gx1   <= '0;
            gy1   <= '0;
            for (int r = 0; r < NROWS; r++) begin
                word_q[r]  <= '0;
                carry_q[r] <= '0;
            end
        end else begin
            col_q <= col_d;
            sol_q <= sol_d;
            gx0   <= gx0_d;
            gy0   <= gy0_d;
            gx1   <= gx1_d;
            gy1   <= gy1_d;
            for (int r = 0; r < NROWS; r++) begin
                word_q[r]  <= word_d[r];
                carry_q[r] <= carry_d[r];
            end
        end
    end

    assign col = col_q;
    assign sol = sol_q;
endmodule

// File: tb/tb_canny_sobel_window.sv
// Directed bench for canny_sobel_window: hand-computed gradients for flat, edge, ramp, stall and reset cases.
module tb_canny_sobel_window;
    localparam logic [63:0] FLAT = 64'h8080_8080_8080_8080;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ZERO = 64'h0;
    // Pixel k = 10*k, pixel 0 in the low byte.
    localparam logic [63:0] RAMP = 64'h463C_3228_1E14_0A00;

    logic               nclk = 1'b0;
    logic               reset;
    logic               load;
    logic               line_start;
    logic [63:0]        rowA, rowB, rowC, rowD;
    logic               load_ready;
    logic               out_valid;
    logic               out_ready;
    logic signed [10:0] gx0, gy0, gx1, gy1;
    logic [2:0]         col;
    logic               sol;
    logic               dut_state;

    int checks = 0;
    int errors = 0;

    canny_sobel_window dut (
        .nclk(nclk), .reset(reset), .load(load), .line_start(line_start),
        .rowA(rowA), .rowB(rowB), .rowC(rowC), .rowD(rowD),
        .load_ready(load_ready), .out_valid(out_valid), .out_ready(out_ready),
        .gx0(gx0), .gy0(gy0), .gx1(gx1), .gy1(gy1),
        .col(col), .sol(sol), .state(dut_state)
    );

    always #5 nclk = ~nclk;

    task automatic step();
        @(negedge nclk);
    endtask

    // Presents one word for a single cycle from IDLE; returns at the negedge where beat 0 is visible.
    task automatic load_word(input logic [63:0] a, b, c, d, input logic ls);
        @(negedge nclk);
        rowA = a; rowB = b; rowC = c; rowD = d;
        line_start = ls;
        load = 1'b1;
        @(negedge nclk);
        load = 1'b0;
        line_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; line_start = 1'b0; out_ready = 1'b0;
        rowA = ZERO; rowB = ZERO; rowC = ZERO; rowD = ZERO;
        repeat (3) step();
        reset = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b want 0", out_valid); errors++; end
        checks++; if (load_ready !== 1'b1) begin $display("FAIL reset_load_ready got %b want 1", load_ready); errors++; end
        checks++; if (col !== 3'd0) begin $display("FAIL reset_col got %0d want 0", col); errors++; end
        checks++; if (sol !== 1'b0) begin $display("FAIL reset_sol got %b want 0", sol); errors++; end
        checks++; if (dut_state !== 1'b0) begin $display("FAIL reset_state got %b want 0", dut_state); errors++; end
        checks++;
        if (gx0 !== 11'sd0 || gy0 !== 11'sd0 || gx1 !== 11'sd0 || gy1 !== 11'sd0) begin
            $display("FAIL reset_grad got %0d %0d %0d %0d want all 0", gx0, gy0, gx1, gy1); errors++;
        end
    endtask

    task automatic test_flat();
        logic signed [10:0] e_gx;
        out_ready = 1'b1;
        load_word(FLAT, FLAT, FLAT, FLAT, 1'b1);
        for (int j = 0; j < 8; j++) begin
            e_gx = (j < 2) ? 11'sd512 : 11'sd0;
            checks++; if (out_valid !== 1'b1) begin $display("FAIL flat_valid beat %0d got %b want 1", j, out_valid); errors++; end
            checks++; if (col !== 3'(j)) begin $display("FAIL flat_col got %0d want %0d", col, j); errors++; end
            checks++; if (sol !== 1'b1) begin $display("FAIL flat_sol col %0d got %b want 1", j, sol); errors++; end
            checks++;
            if (gx0 !== e_gx || gx1 !== e_gx) begin
                $display("FAIL flat_gx col %0d got %0d %0d want %0d", j, gx0, gx1, e_gx); errors++;
            end
            checks++;
            if (gy0 !== 11'sd0 || gy1 !== 11'sd0) begin
                $display("FAIL flat_gy col %0d got %0d %0d want 0", j, gy0, gy1); errors++;
            end
            checks++;
            if (load_ready !== (j == 7)) begin
                $display("FAIL flat_load_ready col %0d got %b want %b", j, load_ready, (j == 7)); errors++;
            end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin $display("FAIL flat_idle_valid got %b want 0", out_valid); errors++; end
        checks++; if (load_ready !== 1'b1) begin $display("FAIL flat_idle_ready got %b want 1", load_ready); errors++; end
    endtask

    task automatic test_vertical();
        load_word(ZERO, ZERO, ONES, ONES, 1'b1);
        repeat (8) step();
        load_word(ZERO, ZERO, ONES, ONES, 1'b0);
        for (int j = 0; j < 8; j++) begin
            checks++; if (col !== 3'(j)) begin $display("FAIL vert_col got %0d want %0d", col, j); errors++; end
            checks++; if (sol !== 1'b0) begin $display("FAIL vert_sol col %0d got %b want 0", j, sol); errors++; end
            checks++;
            if (gy0 !== 11'sd1020 || gy1 !== 11'sd1020) begin
                $display("FAIL vert_gy col %0d got %0d %0d want 1020", j, gy0, gy1); errors++;
            end
            checks++;
            if (gx0 !== 11'sd0 || gx1 !== 11'sd0) begin
                $display("FAIL vert_gx col %0d got %0d %0d want 0", j, gx0, gx1); errors++;
            end
            step();
        end
    endtask

    task automatic test_top_edge();
        logic signed [10:0] e_gy0;
        load_word(ONES, ZERO, ZERO, ZERO, 1'b1);
        for (int j = 0; j < 8; j++) begin
            e_gy0 = (j == 0) ? -11'sd255 : (j == 1) ? -11'sd765 : -11'sd1020;
            checks++; if (gy0 !== e_gy0) begin $display("FAIL top_gy0 col %0d got %0d want %0d", j, gy0, e_gy0); errors++; end
            checks++; if (gy1 !== 11'sd0) begin $display("FAIL top_gy1 col %0d got %0d want 0", j, gy1); errors++; end
            step();
        end
    endtask

    task automatic test_stall();
        load_word(ZERO, ZERO, RAMP, RAMP, 1'b1);
        repeat (3) step();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (col !== 3'd3) begin $display("FAIL stall_col cyc %0d got %0d want 3", k, col); errors++; end
            checks++; if (out_valid !== 1'b1) begin $display("FAIL stall_valid cyc %0d got %b want 1", k, out_valid); errors++; end
            checks++; if (load_ready !== 1'b0) begin $display("FAIL stall_ready cyc %0d got %b want 0", k, load_ready); errors++; end
            checks++;
            if (gx0 !== 11'sd20 || gy0 !== 11'sd80 || gx1 !== 11'sd60 || gy1 !== 11'sd80) begin
                $display("FAIL stall_grad cyc %0d got %0d %0d %0d %0d want 20 80 60 80", k, gx0, gy0, gx1, gy1); errors++;
            end
        end
        out_ready = 1'b1;
        step();
        checks++; if (col !== 3'd4) begin $display("FAIL resume_col got %0d want 4", col); errors++; end
        checks++;
        if (gx0 !== 11'sd20 || gy0 !== 11'sd120 || gx1 !== 11'sd60 || gy1 !== 11'sd120) begin
            $display("FAIL resume_grad got %0d %0d %0d %0d want 20 120 60 120", gx0, gy0, gx1, gy1); errors++;
        end
        repeat (4) step();
    endtask

    task automatic test_back_to_back();
        step();
        rowA = FLAT; rowB = FLAT; rowC = FLAT; rowD = FLAT;
        line_start = 1'b1;
        load = 1'b1;
        step();
        line_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_valid !== 1'b1) begin $display("FAIL b2b_valid beat %0d got %b want 1", i, out_valid); errors++; end
            checks++; if (col !== 3'(i % 8)) begin $display("FAIL b2b_col beat %0d got %0d want %0d", i, col, i % 8); errors++; end
            checks++; if (sol !== (i < 8)) begin $display("FAIL b2b_sol beat %0d got %b want %b", i, sol, (i < 8)); errors++; end
            if (i == 0) begin
                checks++; if (gx0 !== 11'sd512) begin $display("FAIL b2b_gx0_w1 got %0d want 512", gx0); errors++; end
            end
            if (i == 8) begin
                checks++;
                if (gx0 !== 11'sd0 || gx1 !== 11'sd0) begin
                    $display("FAIL b2b_carry_gx got %0d %0d want 0", gx0, gx1); errors++;
                end
                load = 1'b0;
            end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin $display("FAIL b2b_end_valid got %b want 0", out_valid); errors++; end
    endtask

    task automatic test_reset_mid();
        logic signed [10:0] e_gx;
        load_word(FLAT, FLAT, FLAT, FLAT, 1'b1);
        repeat (4) step();
        checks++; if (col !== 3'd4) begin $display("FAIL rmid_pre_col got %0d want 4", col); errors++; end
        reset = 1'b1;
        load = 1'b1;
        line_start = 1'b1;
        step();
        reset = 1'b0;
        load = 1'b0;
        line_start = 1'b0;
        checks++; if (out_valid !== 1'b0) begin $display("FAIL rmid_valid got %b want 0", out_valid); errors++; end
        checks++; if (load_ready !== 1'b1) begin $display("FAIL rmid_ready got %b want 1", load_ready); errors++; end
        checks++; if (col !== 3'd0) begin $display("FAIL rmid_col got %0d want 0", col); errors++; end
        load_word(FLAT, FLAT, FLAT, FLAT, 1'b0);
        for (int j = 0; j < 8; j++) begin
            e_gx = (j < 2) ? 11'sd512 : 11'sd0;
            checks++;
            if (gx0 !== e_gx || gx1 !== e_gx) begin
                $display("FAIL rmid_gx col %0d got %0d %0d want %0d", j, gx0, gx1, e_gx); errors++;
            end
            checks++; if (sol !== 1'b0) begin $display("FAIL rmid_sol col %0d got %b want 0", j, sol); errors++; end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_vertical();
        test_top_edge();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
